pe_buf_read_arbiter: RTL
========================

// Module: pe_buf_read_arbiter
// PURPOSE
//   Shares one global-buffer read port (ifmap, filter or psum buffer) among NUM_PE processing elements.
//   Each PE raises its buffer read-enable as a level request.
//   The arbiter grants one PE at a time in round-robin order, holding the grant for a burst of up to
//   MAX_BURST words, and steers the 1-cycle-latency buffer data back to the granted PE with a per-PE valid.
//   It sits between the PE array and each global buffer; one instance is used per buffer type.
// PARAMETERS
//   NUM_PE     4   number of requesting PEs
//   WIDTH      4   data word width, equal to the PE width
//   MAX_BURST  4   maximum words issued per grant (>=1)
//   ID_W       $clog2(NUM_PE)     grant-index width (derived)
//   BC_W       $clog2(MAX_BURST+1) burst-counter width (derived)
// PORTS
//   clk        in   1              clock, rising edge
//   rst        in   1              asynchronous reset, active-high
//   pe_req     in   NUM_PE         per-PE read request (the PE's read_en_*_buf), level
//   pe_valid   out  NUM_PE         one-hot; data on pe_data belongs to this PE this cycle
//   pe_data    out  WIDTH          buf_dout forwarded, common to all PEs
//   pe_stall   out  NUM_PE         request pending but not issued this cycle
//   buf_ren    out  1              global buffer read strobe
//   buf_empty  in   1              global buffer has no data
//   buf_dout   in   WIDTH          buffer data, valid the cycle after an accepted buf_ren
//   grant_id   out  ID_W           current owner; meaningful only in GRANT
//   busy       out  1              state != IDLE or a read is in flight
// BEHAVIOUR
//   Reset values: state=IDLE, rr_ptr=NUM_PE-1, burst_cnt=0, rd_pend=0, pend_id=0.
//     All outputs are 0 except pe_stall, which follows pe_req.
//   States:
//     IDLE:  if |pe_req, pick the first requesting PE searching from rr_ptr+1 (mod NUM_PE).
//            Register it as grant_id and go to GRANT; burst_cnt<=0.
//            No buf_ren is issued in IDLE (1-cycle arbitration bubble).
//     GRANT: buf_ren = pe_req[grant_id] & ~buf_empty.
//            Each issued read increments burst_cnt.
//            Release (next state IDLE, rr_ptr<=grant_id) when either:
//              - pe_req[grant_id]==0, or
//              - a read issues with burst_cnt==MAX_BURST-1.
//            Release and the last read may coincide.
//   Data return:
//     - rd_pend<=buf_ren and pend_id<=grant_id every cycle.
//     - pe_valid[i] = rd_pend & (pend_id==i), combinational. Latency is exactly 1 cycle from buf_ren.
//     - pe_data = buf_dout, unregistered.
//   buf_empty in GRANT: no read issues, burst_cnt holds, and the grant is kept while the request stays high.
//   Stall: pe_stall[i] = pe_req[i] & ~(state==GRANT & grant_id==i & buf_ren).
//   Fairness:
//     - A PE cannot regain the grant while another PE requests; the pointer moves past it on release.
//     - A lone requester is re-granted after 1 IDLE bubble.
//   Simultaneous requests in IDLE: round-robin order resolves them; ties are impossible.
//   Request dropped in the same cycle as the last burst read: a single release, no double pointer update.
//   Reset asserted mid-burst:
//     - Immediate return to IDLE.
//     - rd_pend is cleared, so the in-flight word is discarded and no pe_valid pulses after reset.
//   MAX_BURST=1: every grant issues at most one word and then re-arbitrates.
//   Invariants: pe_valid is one-hot or zero, and buf_ren is never high while buf_empty is high.
// STRUCTURE
//   Package pe_arb_pkg:
//     - state typedef/localparams IDLE=1'b0, GRANT=1'b1
//     - helper function for the modulo-NUM_PE increment
//   Sub-module rr_priority_picker (NUM_PE):
//     - inputs req vector and ptr; outputs winner index and any_req
//     - purely combinational rotate / priority-encode
//   Top: FSM, burst counter, rr_ptr register, pend_id/rd_pend pipeline register.
// TESTING
//   1. Single PE: pe_req=4'b0001 for 10 cycles, buf never empty
//      -> buf_ren pattern 0,1,1,1,1,0,1,1,1,1.
//      -> pe_valid[0] follows each buf_ren one cycle later.
//   2. All four request continuously (MAX_BURST=4)
//      -> grants in order 0,1,2,3,0.
//      -> each grant issues 4 reads with one bubble between grants.
//      -> pe_data equals buf_dout on the tagged PE.
//   3. PE2 granted, buf_empty=1 for 3 cycles mid-burst
//      -> buf_ren=0 and pe_stall[2]=1 for those cycles; burst_cnt holds.
//      -> the burst completes with 4 words total.
//   4. PE1 drops pe_req after 2 words
//      -> release and rr_ptr=1.
//      -> with PE1 and PE3 then requesting, PE3 is granted next.
//   5. rst pulsed the cycle after a buf_ren to PE0
//      -> no pe_valid pulse; state IDLE; all outputs at reset values.
//   6. Random req/buf_empty, 10k cycles, scoreboard per PE
//      -> the word order per PE matches the buffer order.
//      -> pe_valid is never multi-hot, and no PE waits > NUM_PE*(MAX_BURST+1) issue cycles.

Source files
------------

// File: rtl/pe_arb_pkg.sv
// Shared types and helpers for the PE global-buffer read arbiter.
package pe_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Increment an index and wrap to zero at n.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin picker: first requester found searching upward from ptr+1, wrapping.
module rr_priority_picker
  import pe_arb_pkg::*;
#(
  parameter int NUM_PE = 4,
  parameter int ID_W   = $clog2(NUM_PE)
) (
  input  logic [NUM_PE-1:0] req,
  input  logic [ID_W-1:0]   ptr,
  output logic [ID_W-1:0]   winner,
  output logic              any_req
);

  int unsigned idx;
  logic        found;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = wrap_inc(32'(ptr), NUM_PE);
    for (int k = 0; k < NUM_PE; k++) begin
      if (!found && req[idx[ID_W-1:0]]) begin
        winner = idx[ID_W-1:0];
        found  = 1'b1;
      end
      idx = wrap_inc(idx, NUM_PE);
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/pe_buf_read_arbiter.sv
// Shares one global-buffer read port among NUM_PE processing elements with
// round-robin bursts of up to MAX_BURST words and 1-cycle data return.
module pe_buf_read_arbiter
  import pe_arb_pkg::*;
#(
  parameter  int NUM_PE    = 4,
  parameter  int WIDTH     = 4,
  parameter  int MAX_BURST = 4,
  localparam int ID_W      = $clog2(NUM_PE),
  localparam int BC_W      = $clog2(MAX_BURST + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_PE-1:0] pe_req,
  output logic [NUM_PE-1:0] pe_valid,
  output logic [WIDTH-1:0]  pe_data,
  output logic [NUM_PE-1:0] pe_stall,
  output logic              buf_ren,
  input  logic              buf_empty,
  input  logic [WIDTH-1:0]  buf_dout,
  output logic [ID_W-1:0]   grant_id,
  output logic              busy,
  output arb_state_e        dbg_state
);

  // Handshake: a PE holds pe_req as a level; a word is taken from the buffer in
  // any cycle where buf_ren is high (never while buf_empty), and that word
  // appears on pe_data exactly one cycle later with pe_valid set for its owner.
  // pe_stall marks requesters not served this cycle.

  arb_state_e       state, state_nx;
  logic [ID_W-1:0]  grant_q, rr_ptr, pend_id, pick_id;
  logic [BC_W-1:0]  burst_cnt;
  logic             rd_pend, any_req, last_rd, release_grant;

  rr_priority_picker #(
    .NUM_PE (NUM_PE),
    .ID_W   (ID_W)
  ) u_picker (
    .req     (pe_req),
    .ptr     (rr_ptr),
    .winner  (pick_id),
    .any_req (any_req)
  );

  always_comb begin
    state_nx      = state;
    buf_ren       = 1'b0;
    last_rd       = 1'b0;
    release_grant = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) state_nx = GRANT;
      end
      GRANT: begin
        buf_ren       = pe_req[grant_q] & ~buf_empty;
        last_rd       = buf_ren & (burst_cnt == BC_W'(MAX_BURST - 1));
        release_grant = ~pe_req[grant_q] | last_rd;
        if (release_grant) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    pe_valid = '0;
    pe_stall = pe_req;
    for (int i = 0; i < NUM_PE; i++) begin
      if (rd_pend && pend_id == ID_W'(i)) pe_valid[i] = 1'b1;
      if (buf_ren && grant_q == ID_W'(i)) pe_stall[i] = 1'b0;
    end
  end

  assign pe_data   = buf_dout;
  assign grant_id  = grant_q;
  assign busy      = (state != IDLE) | rd_pend;
  assign dbg_state = state;

  // rd_pend/pend_id tag the word that returns next cycle; reset drops it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      grant_q   <= '0;
      rr_ptr    <= ID_W'(NUM_PE - 1);
      burst_cnt <= '0;
      rd_pend   <= 1'b0;
      pend_id   <= '0;
    end else begin
      state   <= state_nx;
      rd_pend <= buf_ren;
      pend_id <= grant_q;
      if (state == IDLE && any_req) begin
        grant_q   <= pick_id;
        burst_cnt <= '0;
      end
      if (buf_ren) burst_cnt <= burst_cnt + 1'b1;
      if (release_grant) rr_ptr <= grant_q;
    end
  end

endmodule
